cc_branch_unit: RTL and testbench

//  Sink side of the execute-stage ALU flag interface. Holds the architectural

---
 rtl/cc_branch_unit.sv | 127 ++++++++++++
 tb/tb_cc_branch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_branch_unit.sv
// Condition-code register, in-flight flag-writer tracking and conditional branch
// resolution for the execute stage; registered taken/target/flush pulse to fetch.
module cc_branch_unit #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned PEND_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_CC_WE,
    input  logic [3:0]       i_CCodes,
    input  logic             i_CC_Issue,
    input  logic             i_Br_Valid,
    output logic             o_Br_Ready,
    input  logic [3:0]       i_Br_Cond,
    input  logic [WIDTH-1:0] i_Br_PC,
    input  logic [WIDTH-1:0] i_Br_Disp,
    output logic             o_Rslt_Valid,
    output logic             o_Taken,
    output logic [WIDTH-1:0] o_Target,
    output logic             o_Flush,
    output logic [3:0]       o_CC,
    output logic             o_CC_Full
);

    typedef enum logic [1:0] {IDLE, WAIT_CC, EVAL} state_t;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    state_t            state;
    logic [3:0]        cc_reg;
    logic [3:0]        cc_next;
    logic [PEND_W-1:0] pend;
    logic [PEND_W-1:0] pend_next;
    logic [3:0]        cond_q;
    logic [WIDTH-1:0]  pc_q;
    logic [WIDTH-1:0]  disp_q;
    logic [3:0]        eval_cond;
    logic [WIDTH-1:0]  eval_pc;
    logic [WIDTH-1:0]  eval_disp;
    logic              fire;
    logic              taken_next;

    // Flags are {V,C,N,Z} at bits 3..0; bit 3 of cond inverts the sense.
    function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] cc);
        logic z, n, c, v, base;
        z = cc[0];
        n = cc[1];
        c = cc[2];
        v = cc[3];
        case (cond[2:0])
            3'b000:  base = 1'b1;
            3'b001:  base = ~c;
            3'b010:  base = ~v;
            3'b011:  base = z;
            3'b100:  base = ~(n ^ v);
            3'b101:  base = ~(z | (n ^ v));
            3'b110:  base = ~n;
            default: return 1'b0;
        endcase
        return base ^ cond[3];
    endfunction

    always_comb begin
        pend_next = pend;
        if (i_CC_Issue && !i_CC_WE && pend != PEND_MAX)
            pend_next = pend + PEND_ONE;
        else if (i_CC_WE && !i_CC_Issue && pend != '0)
            pend_next = pend - PEND_ONE;
    end

    // Resolving on the same edge as the final flag write must see that write.
    always_comb begin
        cc_next    = i_CC_WE ? i_CCodes : cc_reg;
        eval_cond  = (state == IDLE) ? i_Br_Cond : cond_q;
        eval_pc    = (state == IDLE) ? i_Br_PC   : pc_q;
        eval_disp  = (state == IDLE) ? i_Br_Disp : disp_q;
        fire       = ((state == IDLE) && i_Br_Valid &&
                      ((i_Br_Cond[2:0] == 3'b000) || (pend_next == '0))) ||
                     ((state == WAIT_CC) && (pend_next == '0));
        taken_next = cond_true(eval_cond, cc_next);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cc_reg       <= '0;
            pend         <= '0;
            cond_q       <= '0;
            pc_q         <= '0;
            disp_q       <= '0;
            o_Rslt_Valid <= 1'b0;
            o_Taken      <= 1'b0;
            o_Target     <= '0;
            o_Flush      <= 1'b0;
        end else begin
            cc_reg       <= cc_next;
            pend         <= pend_next;
            o_Rslt_Valid <= 1'b0;
            o_Flush      <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_Br_Valid) begin
                        cond_q <= i_Br_Cond;
                        pc_q   <= i_Br_PC;
                        disp_q <= i_Br_Disp;
                        state  <= fire ? EVAL : WAIT_CC;
                    end
                end
                WAIT_CC: if (fire) state <= EVAL;
                EVAL:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (fire) begin
                o_Rslt_Valid <= 1'b1;
                o_Taken      <= taken_next;
                o_Target     <= eval_pc + eval_disp;
                o_Flush      <= taken_next;
            end
        end
    end

    assign o_Br_Ready = (state == IDLE);
    assign o_CC       = cc_reg;
    assign o_CC_Full  = (pend == PEND_MAX);

endmodule

// File: tb/tb_cc_branch_unit.sv
// Directed bench for cc_branch_unit: expected results queued at branch accept and
// compared whenever the unit pulses o_Rslt_Valid.
module tb_cc_branch_unit;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             i_CC_WE;
    logic [3:0]       i_CCodes;
    logic             i_CC_Issue;
    logic             i_Br_Valid;
    logic             o_Br_Ready;
    logic [3:0]       i_Br_Cond;
    logic [WIDTH-1:0] i_Br_PC;
    logic [WIDTH-1:0] i_Br_Disp;
    logic             o_Rslt_Valid;
    logic             o_Taken;
    logic [WIDTH-1:0] o_Target;
    logic             o_Flush;
    logic [3:0]       o_CC;
    logic             o_CC_Full;

    typedef struct packed {
        logic             taken;
        logic [WIDTH-1:0] target;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    cc_branch_unit #(.WIDTH(WIDTH), .PEND_W(2)) dut (
        .clk(clk), .reset(reset),
        .i_CC_WE(i_CC_WE), .i_CCodes(i_CCodes), .i_CC_Issue(i_CC_Issue),
        .i_Br_Valid(i_Br_Valid), .o_Br_Ready(o_Br_Ready), .i_Br_Cond(i_Br_Cond),
        .i_Br_PC(i_Br_PC), .i_Br_Disp(i_Br_Disp),
        .o_Rslt_Valid(o_Rslt_Valid), .o_Taken(o_Taken), .o_Target(o_Target),
        .o_Flush(o_Flush), .o_CC(o_CC), .o_CC_Full(o_CC_Full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Written per full condition code, independent of the bit-3 inversion trick.
    function automatic logic model_taken(input logic [3:0] cond, input logic [3:0] cc);
        logic z, n, c, v;
        z = cc[0]; n = cc[1]; c = cc[2]; v = cc[3];
        case (cond)
            4'h0: return 1'b1;
            4'h1: return !c;
            4'h2: return !v;
            4'h3: return z;
            4'h4: return n == v;
            4'h5: return !z && (n == v);
            4'h6: return !n;
            4'h7: return 1'b0;
            4'h8: return 1'b0;
            4'h9: return c;
            4'hA: return v;
            4'hB: return !z;
            4'hC: return n != v;
            4'hD: return z || (n != v);
            4'hE: return n;
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b1 && o_Rslt_Valid === 1'b1) begin
            check("result_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("taken", 64'(o_Taken), 64'(e.taken));
                check("target", 64'(o_Target), 64'(e.target));
                check("flush", 64'(o_Flush), 64'(e.taken));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cc(input logic [3:0] f);
        i_CC_WE  = 1'b1;
        i_CCodes = f;
        tick();
        i_CC_WE  = 1'b0;
    endtask

    task automatic issue(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            i_CC_Issue = 1'b1;
            tick();
        end
        i_CC_Issue = 1'b0;
    endtask

    task automatic send(input logic [3:0] cond, input logic [WIDTH-1:0] pc,
                        input logic [WIDTH-1:0] disp, input logic exp_taken,
                        input logic do_push);
        exp_t e;
        check("ready_before_accept", 64'(o_Br_Ready), 64'd1);
        i_Br_Valid = 1'b1;
        i_Br_Cond  = cond;
        i_Br_PC    = pc;
        i_Br_Disp  = disp;
        if (do_push) begin
            e.taken  = exp_taken;
            e.target = pc + disp;
            sb.push_back(e);
        end
        tick();
        i_Br_Valid = 1'b0;
    endtask

    task automatic expect_pulse(input string tag, input logic exp);
        @(negedge clk);
        check(tag, 64'(o_Rslt_Valid), 64'(exp));
        tick();
    endtask

    initial begin
        reset = 1'b0;
        i_CC_WE = 1'b0; i_CCodes = '0; i_CC_Issue = 1'b0;
        i_Br_Valid = 1'b0; i_Br_Cond = '0; i_Br_PC = '0; i_Br_Disp = '0;
        repeat (3) tick();
        reset = 1'b1;

        // reset state over idle cycles
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_valid", 64'(o_Rslt_Valid), 64'd0);
            check("rst_ready", 64'(o_Br_Ready), 64'd1);
            check("rst_cc", 64'(o_CC), 64'd0);
            check("rst_full", 64'(o_CC_Full), 64'd0);
            check("rst_target", 64'(o_Target), 64'd0);
            check("rst_taken", 64'(o_Taken), 64'd0);
            check("rst_flush", 64'(o_Flush), 64'd0);
        end
        tick();

        // BEQ with Z set, immediate resolution
        set_cc(4'b0001);
        check("cc_written", 64'(o_CC), 64'd1);
        send(4'b0011, 32'h100, 32'h20, 1'b1, 1'b1);
        @(negedge clk);
        check("beq_ready_in_eval", 64'(o_Br_Ready), 64'd0);
        check("beq_pulse", 64'(o_Rslt_Valid), 64'd1);
        tick();
        @(negedge clk);
        check("pulse_one_cycle", 64'(o_Rslt_Valid), 64'd0);
        check("target_hold", 64'(o_Target), 64'h120);
        check("taken_hold", 64'(o_Taken), 64'd1);
        check("flush_drop", 64'(o_Flush), 64'd0);
        tick();

        // BLT waits for two writers; result follows the final write
        issue(2);
        send(4'b1100, 32'h200, 32'h40, 1'b1, 1'b1);
        @(negedge clk);
        check("blt_wait_ready", 64'(o_Br_Ready), 64'd0);
        tick();
        expect_pulse("blt_wait", 1'b0);
        set_cc(4'b0010);
        expect_pulse("blt_first_we", 1'b0);
        set_cc(4'b1000);
        expect_pulse("blt_second_we", 1'b1);

        issue(2);
        send(4'b1100, 32'h300, 32'h8, 1'b0, 1'b1);
        set_cc(4'b1000);
        expect_pulse("blt2_first_we", 1'b0);
        set_cc(4'b1010);
        expect_pulse("blt2_second_we", 1'b1);

        // saturation at max, BRA/BNV bypass pending writers
        issue(3);
        check("full_at_3", 64'(o_CC_Full), 64'd1);
        issue(1);
        check("full_sat", 64'(o_CC_Full), 64'd1);
        send(4'b0000, 32'h400, 32'h10, 1'b1, 1'b1);
        expect_pulse("bra_pending", 1'b1);
        send(4'b1000, 32'h500, 32'h10, 1'b0, 1'b1);
        expect_pulse("bnv_pending", 1'b1);
        set_cc(4'b0000);
        set_cc(4'b0000);
        check("full_cleared", 64'(o_CC_Full), 64'd0);
        i_CC_Issue = 1'b1; i_CC_WE = 1'b1; i_CCodes = 4'b0000;
        tick();
        i_CC_Issue = 1'b0; i_CC_WE = 1'b0;
        send(4'b0011, 32'h600, 32'h4, 1'b1, 1'b1);
        expect_pulse("incdec_wait", 1'b0);
        expect_pulse("incdec_wait2", 1'b0);
        set_cc(4'b0001);
        expect_pulse("incdec_retire", 1'b1);
        set_cc(4'b0000);
        issue(1);
        send(4'b1011, 32'h700, 32'h4, 1'b1, 1'b1);
        expect_pulse("dec0_wait", 1'b0);
        set_cc(4'b0000);
        expect_pulse("dec0_retire", 1'b1);

        // reserved conditions
        set_cc(4'b1111);
        send(4'b0111, 32'h800, 32'h4, 1'b0, 1'b1);
        expect_pulse("rsv0", 1'b1);
        send(4'b1111, 32'h800, 32'h4, 1'b0, 1'b1);
        expect_pulse("rsv1", 1'b1);

        // target wrap and negative displacement
        send(4'b0000, 32'hFFFF_FFF0, 32'h20, 1'b1, 1'b1);
        expect_pulse("wrap", 1'b1);
        check("wrap_target", 64'(o_Target), 64'h10);
        send(4'b0000, 32'h1000, 32'hFFFF_FFFC, 1'b1, 1'b1);
        expect_pulse("neg_disp", 1'b1);
        check("neg_target", 64'(o_Target), 64'hFFC);

        // flag write during EVAL does not disturb the current result
        set_cc(4'b0001);
        send(4'b0011, 32'h900, 32'h4, 1'b1, 1'b1);
        i_CC_WE = 1'b1; i_CCodes = 4'b0000;
        @(negedge clk);
        check("eval_we_pulse", 64'(o_Rslt_Valid), 64'd1);
        tick();
        i_CC_WE = 1'b0;
        check("eval_we_cc", 64'(o_CC), 64'd0);

        // full condition/flag sweep
        for (int f = 0; f < 16; f++) begin
            set_cc(4'(f));
            for (int c = 0; c < 16; c++) begin
                send(4'(c), 32'(f * 256 + c * 4), 32'h40, model_taken(4'(c), 4'(f)), 1'b1);
                expect_pulse("sweep", 1'b1);
            end
        end

        // reset while waiting drops the branch
        issue(1);
        send(4'b0011, 32'hA00, 32'h4, 1'b0, 1'b0);
        expect_pulse("pre_reset_wait", 1'b0);
        reset = 1'b0;
        #1;
        check("reset_ready", 64'(o_Br_Ready), 64'd1);
        check("reset_target", 64'(o_Target), 64'd0);
        tick();
        reset = 1'b1;
        set_cc(4'b0001);
        expect_pulse("post_reset_none", 1'b0);
        expect_pulse("post_reset_none2", 1'b0);
        send(4'b0011, 32'hB00, 32'h4, 1'b1, 1'b1);
        expect_pulse("post_reset_imm", 1'b1);

        repeat (2) tick();
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
